serial_frame_tx: RTL
====================

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the payload width in bits (minimum 1).
REQ-002 Parameter BIT_CYCLES, default 4, SHALL set the clock cycles each serial bit is held (minimum 1).
REQ-003 clk  input  1  SHALL be the clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset, asynchronous, active-low.
REQ-005 tx_data  input  DATA_W  SHALL be the parallel word to transmit; sampled only on handshake.
REQ-006 tx_valid  input  1  SHALL indicate that tx_data holds a word to send.
REQ-007 tx_ready  output  1  SHALL indicate that the block can accept a word this cycle.
REQ-008 data_out  output  1  SHALL be the registered serial line; idle level 1.
REQ-009 busy  output  1  SHALL be 1 while a frame is on the line (START through STOP).
REQ-010 frame_done  output  1  SHALL pulse high for one cycle when a frame completes.

Function
REQ-011 Frame format SHALL be: start bit 0, DATA_W data bits LSB first, even-parity bit, stop bit 1.
REQ-012 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-013 tx_ready SHALL be 1 only in IDLE; handshake SHALL occur when tx_valid and tx_ready are both 1 on a rising edge.
REQ-014 On handshake, tx_data SHALL be captured into an internal shift register, and the FSM SHALL go to START.
REQ-015 data_out SHALL show the start bit in the first cycle after the handshake edge (latency 1).
REQ-016 Each bit SHALL be held exactly BIT_CYCLES cycles, timed by a bit counter of width max(1, clog2(BIT_CYCLES)).
REQ-017 DATA SHALL emit DATA_W bits and then move to PARITY, using a bit index that wraps to 0 on exit.
REQ-018 Parity SHALL be accumulated by toggling a register on each 1 bit sent, cleared on handshake.
REQ-019 The parity bit SHALL equal the XOR of all data bits.
REQ-020 STOP SHALL return to IDLE after BIT_CYCLES cycles.
REQ-021 A frame SHALL occupy exactly (DATA_W+3)*BIT_CYCLES cycles.
REQ-022 frame_done SHALL be 1 in the first IDLE cycle after STOP, coincident with tx_ready rising.
REQ-023 Back-to-back frames, with tx_valid held, SHALL have exactly one idle cycle (data_out=1) between stop bit and next start bit.
REQ-024 tx_valid asserted while busy SHALL be ignored, and the frame in flight SHALL be unaffected.
REQ-025 Changes on tx_data after the handshake SHALL NOT affect the frame in flight.
REQ-026 BIT_CYCLES=1 SHALL produce one bit per clock with no skipped or repeated bits.

Reset
REQ-027 While rst_n=0: data_out=1, tx_ready=0, busy=0, frame_done=0, and FSM=IDLE, with counters, shift register and parity cleared.
REQ-028 tx_ready SHALL rise in the first clock edge after rst_n deasserts.
REQ-029 Reset mid-frame SHALL abandon the frame immediately (data_out=1), with no frame_done pulse for it.

Verification
REQ-030 DATA_W=8, BIT_CYCLES=4, send 0xA5 -> line 0,1,0,1,0,0,1,0,1,0(parity),1, each held 4 cycles; 44 busy cycles; frame_done 1 cycle after.
REQ-031 Send 0x07 -> parity bit 1; send 0x00 -> parity bit 0; send 0xFF -> parity bit 0.
REQ-032 tx_valid held high with 0x3C then 0xC3 -> two correct frames separated by exactly one idle cycle; two frame_done pulses.
REQ-033 Pulse tx_valid with 0x55 during DATA of frame 0x81 -> only 0x81 sent; tx_ready stays 0 until its frame_done.
REQ-034 Assert rst_n=0 in the middle of bit 3 of 0xA5 -> data_out=1 the same cycle; no frame_done; the next 0x12 frame is correct.
REQ-035 BIT_CYCLES=1, send 0xA5 -> 11-cycle frame matching the REQ-030 bit sequence.

Source files
------------

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit 0, DATA_W data bits LSB first, even parity, stop bit 1.
// Each bit is held BIT_CYCLES clocks; the serial line and all status outputs come straight from flops.
module serial_frame_tx #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              data_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt,   w_cnt_nxt;
    logic [IDX_W-1:0]    r_idx,   w_idx_nxt;
    logic [DATA_W-1:0]   r_shift, w_shift_nxt;
    logic                r_par,   w_par_nxt;
    logic                r_dout,  w_dout_nxt;
    logic                r_done,  w_done_nxt;
    logic                r_ready;
    logic                r_busy;
    logic                w_bit_end;

    assign w_bit_end  = (r_cnt == CNT_LAST);
    assign tx_ready   = r_ready;
    assign data_out   = r_dout;
    assign busy       = r_busy;
    assign frame_done = r_done;

    // Next-state and next-datapath logic; the line value is loaded as each bit begins
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_bit_end ? {CNT_W{1'b0}} : (r_cnt + CNT_W'(1));
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_dout_nxt  = r_dout;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt  = {CNT_W{1'b0}};
                w_dout_nxt = 1'b1;
                if (tx_valid && r_ready) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = tx_data;
                    w_par_nxt   = 1'b0;
                    w_idx_nxt   = {IDX_W{1'b0}};
                    w_dout_nxt  = 1'b0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_dout_nxt  = r_shift[0];
                    w_par_nxt   = r_par ^ r_shift[0];
                    w_shift_nxt = r_shift >> 1'b1;
                end else begin
                    w_state_nxt = S_START;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_idx == IDX_LAST) begin
                        // Parity already includes the last data bit, toggled when it was emitted
                        w_state_nxt = S_PARITY;
                        w_dout_nxt  = r_par;
                        w_idx_nxt   = {IDX_W{1'b0}};
                    end else begin
                        w_dout_nxt  = r_shift[0];
                        w_par_nxt   = r_par ^ r_shift[0];
                        w_shift_nxt = r_shift >> 1'b1;
                        w_idx_nxt   = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_dout_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_PARITY;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = S_IDLE;
                    w_dout_nxt  = 1'b1;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_STOP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = {CNT_W{1'b0}};
                w_dout_nxt  = 1'b1;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and registered status outputs; tx_ready stays low during reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_idx   <= {IDX_W{1'b0}};
            r_shift <= {DATA_W{1'b0}};
            r_par   <= 1'b0;
            r_dout  <= 1'b1;
            r_done  <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_dout  <= w_dout_nxt;
            r_done  <= w_done_nxt;
            r_ready <= (w_state_nxt == S_IDLE);
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

endmodule
